// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: eight opcodes, carry/borrow and zero flags, one-cycle latency.
// Optional ALU_EXT_FLAGS_EN adds registered Negative and signed Overflow outputs.
module alu_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             ZeroFlag,
  output logic             out_valid
`ifdef ALU_EXT_FLAGS_EN
  ,
  output logic             Negative,
  output logic             Overflow
`endif
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } op_e;

  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_is_add;
  logic             w_is_sub;

  logic [WIDTH-1:0] r_result_p1;
  logic             r_carry_p1;
  logic             r_zero_p1;
  logic             r_vld_p1;

  // INC/DEC reuse the add/subtract paths with a constant-one second operand
  always_comb begin
    w_is_add = (OP == OP_ADD) || (OP == OP_INC);
    w_is_sub = (OP == OP_SUB) || (OP == OP_DEC);
    w_opb    = ((OP == OP_INC) || (OP == OP_DEC)) ? WIDTH'(1) : B;
  end

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (op_e'(OP))
      OP_ADD, OP_INC: {w_carry, w_res} = {1'b0, A} + {1'b0, w_opb};
      OP_SUB, OP_DEC: {w_carry, w_res} = {1'b0, A} - {1'b0, w_opb};
      OP_AND:         w_res = A & B;
      OP_OR:          w_res = A | B;
      OP_XOR:         w_res = A ^ B;
      OP_NOT:         w_res = ~A;
      default:        w_res = '0;
    endcase
  end

`ifdef ALU_EXT_FLAGS_EN
  function automatic logic signed_ovf(input logic is_add, input logic is_sub,
                                      input logic a_msb, input logic b_msb,
                                      input logic r_msb);
    logic ovf;
    ovf = 1'b0;
    if (is_add)      ovf = (a_msb == b_msb) && (r_msb != a_msb);
    else if (is_sub) ovf = (a_msb != b_msb) && (r_msb != a_msb);
    return ovf;
  endfunction

  logic w_ovf;
  logic r_neg_p1;
  logic r_ovf_p1;

  assign w_ovf = signed_ovf(w_is_add, w_is_sub, A[WIDTH-1], w_opb[WIDTH-1], w_res[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_p1 <= 1'b0;
      r_ovf_p1 <= 1'b0;
    end else if (in_valid) begin
      r_neg_p1 <= w_res[WIDTH-1];
      r_ovf_p1 <= w_ovf;
    end
  end

  assign Negative = r_neg_p1;
  assign Overflow = r_ovf_p1;
`endif

  // Stage p1: outputs update only on valid input; flags hold otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result_p1 <= '0;
      r_carry_p1  <= 1'b0;
      r_zero_p1   <= 1'b0;
      r_vld_p1    <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_result_p1 <= w_res;
        r_carry_p1  <= w_carry;
        r_zero_p1   <= (w_res == '0);
      end
    end
  end

  assign Result    = r_result_p1;
  assign CarryOut  = r_carry_p1;
  assign ZeroFlag  = r_zero_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vectors plus randomized stream against
// an arithmetic reference model; define ALU_EXT_FLAGS_EN to cover Negative/Overflow.
module tb_alu_8bit;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] OP;
  logic       in_valid;
  logic [7:0] Result;
  logic       CarryOut;
  logic       ZeroFlag;
  logic       out_valid;
`ifdef ALU_EXT_FLAGS_EN
  logic       Negative;
  logic       Overflow;
`endif

  alu_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .OP       (OP),
    .in_valid (in_valid),
    .Result   (Result),
    .CarryOut (CarryOut),
    .ZeroFlag (ZeroFlag),
    .out_valid(out_valid)
`ifdef ALU_EXT_FLAGS_EN
    ,
    .Negative (Negative),
    .Overflow (Overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int e_res = 0;
  int e_c   = 0;
  int e_z   = 0;
  int e_v   = 0;
  int e_n   = 0;
  int e_o   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  // Reference model: plain integer arithmetic on unsigned and signed views
  task automatic model(input int op, input int a, input int b);
    int s;
    int ss;
    e_o = 0;
    case (op)
      0: begin s = a + b; e_c = (s > 255); ss = to_signed(a) + to_signed(b); e_o = (ss > 127 || ss < -128); end
      1: begin s = a - b; e_c = (a < b);   ss = to_signed(a) - to_signed(b); e_o = (ss > 127 || ss < -128); end
      2: begin s = a & b; e_c = 0; end
      3: begin s = a | b; e_c = 0; end
      4: begin s = a ^ b; e_c = 0; end
      5: begin s = 255 - a; e_c = 0; end
      6: begin s = a + 1; e_c = (a == 255); ss = to_signed(a) + 1; e_o = (ss > 127); end
      default: begin s = a - 1; e_c = (a == 0); ss = to_signed(a) - 1; e_o = (ss < -128); end
    endcase
    e_res = (s + 256) % 256;
    e_z   = (e_res == 0);
    e_n   = (e_res > 127);
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".res"}, int'(Result), e_res);
    check({tag, ".c"},   int'(CarryOut), e_c);
    check({tag, ".z"},   int'(ZeroFlag), e_z);
    check({tag, ".vld"}, int'(out_valid), e_v);
`ifdef ALU_EXT_FLAGS_EN
    check({tag, ".neg"}, int'(Negative), e_n);
    check({tag, ".ovf"}, int'(Overflow), e_o);
`endif
  endtask

  // Called at a negedge: drive one cycle of input, then check after the next edge
  task automatic step(input string tag, input logic v, input int op, input int a, input int b);
    rst_n    = 1'b1;
    in_valid = v;
    OP       = 3'(op);
    A        = 8'(a);
    B        = 8'(b);
    e_v      = v;
    if (v) model(op, a, b);
    @(negedge clk);
    check_outs(tag);
  endtask

  task automatic reset_step(input string tag);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    OP       = 3'($urandom_range(7));
    A        = 8'($urandom);
    B        = 8'($urandom);
    e_res = 0; e_c = 0; e_z = 0; e_v = 0; e_n = 0; e_o = 0;
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; OP = '0;
    @(negedge clk);

    reset_step("rst0");
    reset_step("rst1");

    step("add",  1, 0, 8'h0A, 8'h05);
    step("sub",  1, 1, 8'h0A, 8'h03);
    step("inc",  1, 6, 8'h09, 8'h00);
    step("dec",  1, 7, 8'h01, 8'h00);

    step("and",  1, 2, 8'hFF, 8'h0F);
    step("or",   1, 3, 8'hF0, 8'h0F);
    step("xor",  1, 4, 8'hAA, 8'h55);
    step("not",  1, 5, 8'hA5, 8'h00);

    step("addw", 1, 0, 8'hFF, 8'h01);
    step("subb", 1, 1, 8'h00, 8'h01);
    step("incw", 1, 6, 8'hFF, 8'h00);
    step("decb", 1, 7, 8'h00, 8'h00);
    step("xorz", 1, 4, 8'h5A, 8'h5A);

    step("hadd", 1, 0, 8'h0A, 8'h05);
    for (int i = 0; i < 3; i++)
      step("idle", 0, int'($urandom_range(7)), int'($urandom_range(255)), int'($urandom_range(255)));
    check("hold.res", int'(Result), 8'h0F);

    step("ovadd", 1, 0, 8'h7F, 8'h01);
    step("ovsub", 1, 1, 8'h80, 8'h01);
    step("ovand", 1, 2, 8'hF0, 8'hFF);
    step("ovinc", 1, 6, 8'h7F, 8'h00);
    step("ovdec", 1, 7, 8'h80, 8'h00);

    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        reset_step("midrst");
      end else begin
        step("rnd", logic'($urandom_range(9) != 0), int'($urandom_range(7)),
             int'($urandom_range(255)), int'($urandom_range(255)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit registered arithmetic/logic unit; 3-bit opcode selects one of eight operations on operands A and B.
- Produces an 8-bit result plus carry/borrow and zero flags, registered with one-cycle latency.
- Sits in the datapath as a leaf execution unit, fed by operand registers or decode logic.

Parameters:
- WIDTH, 8, operand/result width; all widths below scale with it, but only 8 is required to be verified.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  8  operand A
- B  input  8  operand B; ignored by NOT, INC, DEC
- OP  input  3  opcode
- in_valid  input  1  operands/opcode valid this cycle
- Result  output  8  registered result
- CarryOut  output  1  registered carry (add/inc) or borrow (sub/dec)
- ZeroFlag  output  1  registered, 1 when Result == 0
- out_valid  output  1  Result/flags updated from a valid input on the previous edge

Behaviour:
- Reset: on a rising clk edge with rst_n=0, Result=8'h00, CarryOut=0, ZeroFlag=0 and out_valid=0. Reset has priority over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear at the outputs after edge N, with out_valid=1 for that cycle.
- No backpressure: a new operation can be accepted every cycle.
- in_valid=0 at an edge (not in reset): out_valid goes to 0; Result, CarryOut and ZeroFlag hold their previous values.
- Opcodes (arithmetic is 9-bit internally; Result = low 8 bits, wrap-around modulo 256):
  - 000 ADD: A+B; CarryOut = bit 8 of the sum.
  - 001 SUB: A-B; CarryOut = borrow, 1 iff A<B unsigned.
  - 010 AND: A&B; CarryOut=0.
  - 011 OR: A|B; CarryOut=0.
  - 100 XOR: A^B; CarryOut=0.
  - 101 NOT: ~A; CarryOut=0.
  - 110 INC: A+1; CarryOut=1 iff A=8'hFF.
  - 111 DEC: A-1; CarryOut=1 iff A=8'h00.
- ZeroFlag is computed from the new result, not the previous one. It is valid for every opcode, including logic operations.
- X/Z on OP while in_valid=1 is not supported. There is no illegal opcode, because all 8 encodings are defined.
- Reset asserted mid-stream: the in-flight result is discarded and the outputs take their reset values at that edge.

Optional Feature:
- Macro ALU_EXT_FLAGS_EN.
- When defined, add two registered output ports:
  - Negative (1 bit) = Result[7].
  - Overflow (1 bit) = signed two's-complement overflow. For ADD/INC: operands share a sign and the result sign differs. For SUB/DEC: A and the subtrahend (B, or 1 for DEC) differ in sign and the result sign differs from A. All logic ops: 0.
  - Both reset to 0, hold with the other outputs when in_valid=0, and follow the same 1-cycle latency.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs and in_valid=1 -> Result=00, CarryOut=0, ZeroFlag=0, out_valid=0. Release rst_n -> first valid operation appears after 1 edge.
- Arithmetic set, one per cycle (each result checked 1 cycle later, out_valid=1):
  - ADD 0A+05 -> 0F, C=0, Z=0
  - SUB 0A-03 -> 07, C=0
  - INC 09 -> 0A
  - DEC 01 -> 00, Z=1, C=0
- Logic set:
  - AND FF&0F -> 0F
  - OR F0|0F -> FF
  - XOR AA^55 -> FF
  - NOT A5 (B=00) -> 5A
  - All with C=0, Z=0.
- Boundaries:
  - ADD FF+01 -> 00, C=1, Z=1
  - SUB 00-01 -> FF, C=1
  - INC FF -> 00, C=1, Z=1
  - DEC 00 -> FF, C=1
  - XOR 5A^5A -> 00, Z=1
- Hold/handshake: ADD 0A+05 with in_valid=1, then in_valid=0 for 3 cycles with changing A/B/OP -> Result stays 0F and out_valid=0 during the idle cycles. Back-to-back valid ops stream one result per cycle.
- With ALU_EXT_FLAGS_EN: ADD 7F+01 -> 80, Overflow=1, Negative=1. SUB 80-01 -> 7F, Overflow=1, Negative=0. AND F0&FF -> Overflow=0, Negative=1.
